// File: rtl/if_id_pipe_hs_if.sv
// Valid/ready handshake bundle carrying {pc, instr} between two pipe stages.
// master drives valid/pc/instr and receives ready; slave is the mirror image.
interface if_id_pipe_hs_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic               valid;
    logic               ready;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;

    modport master (output valid, output pc, output instr, input ready);
    modport slave  (input valid, input pc, input instr, output ready);
endinterface

// File: rtl/if_id_pipe_hs.sv
// Fetch->decode pipe register: 2-entry skid buffer with valid/ready, flush and NOP bubbles.
// Define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module if_id_pipe_hs #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}},
    parameter int                 CNT_W     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    if_id_pipe_hs_if.slave         in_if,
    if_id_pipe_hs_if.master        out_if
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic               in_fire;
    logic               out_fire;

    assign in_fire  = in_if.valid & in_ready_q;
    assign out_fire = out_valid_q & out_if.ready;

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d      = ONE;
                    main_pc_d    = in_if.pc;
                    main_instr_d = in_if.instr;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_pc_d    = in_if.pc;
                    main_instr_d = in_if.instr;
                end else if (in_fire) begin
                    state_d      = FULL;
                    skid_pc_d    = in_if.pc;
                    skid_instr_d = in_if.instr;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d      = ONE;
                    main_pc_d    = skid_pc_q;
                    main_instr_d = skid_instr_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush discards both entries and any beat arriving this cycle.
        if (flush) begin
            state_d      = EMPTY;
            main_pc_d    = '0;
            main_instr_d = NOP_INSTR;
            skid_pc_d    = '0;
            skid_instr_d = NOP_INSTR;
        end
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = out_valid_q;
    assign out_if.pc    = main_pc_q;
    assign out_if.instr = main_instr_q;

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles decode refused a valid entry; flush leaves it alone.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_if.ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_pipe_hs.sv
// Self-checking bench for if_id_pipe_hs: queue-based reference model, directed scenarios, random traffic.
module tb_if_id_pipe_hs;
    localparam int                PC_W      = 32;
    localparam int                INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP      = 32'h0000_0013;
    localparam int                CNT_W     = 4;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    if_id_pipe_hs_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) fetch_if ();
    if_id_pipe_hs_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dec_if ();

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    if_id_pipe_hs #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .in_if(fetch_if.slave),
        .out_if(dec_if.master)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else checks_passed++;
    endtask

    // Reference model: FIFO of up to two beats; the visible entry is the head,
    // or the last beat handed to decode (or the bubble after reset/flush) when empty.
    logic [63:0] mq[$];
    logic [63:0] m_last;
    int          m_cnt;
    bit          model_ok = 0;

    always @(posedge clock) begin
        bit          m_in_fire, m_out_fire;
        logic [63:0] popped;
        m_in_fire  = fetch_if.valid && (mq.size() < 2);
        m_out_fire = (mq.size() > 0) && dec_if.ready;
        if (!reset) begin
            mq.delete();
            m_last   = {32'h0, NOP};
            m_cnt    = 0;
            model_ok = 1;
        end else begin
            if (mq.size() > 0 && !dec_if.ready && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (flush) begin
                mq.delete();
                m_last = {32'h0, NOP};
            end else begin
                if (m_out_fire) begin
                    popped = mq.pop_front();
                    m_last = popped;
                end
                if (m_in_fire) mq.push_back({fetch_if.pc, fetch_if.instr});
            end
        end
    end

    always @(negedge clock) begin
        logic [63:0] vis;
        if (model_ok) begin
            vis = (mq.size() > 0) ? mq[0] : m_last;
            chk("out_valid", {63'h0, dec_if.valid}, {63'h0, (mq.size() > 0)});
            chk("in_ready", {63'h0, fetch_if.ready}, {63'h0, (mq.size() < 2)});
            chk("out_pc", {32'h0, dec_if.pc}, {32'h0, vis[63:32]});
            chk("out_instr", {32'h0, dec_if.instr}, {32'h0, vis[31:0]});
`ifdef PIPE_STALL_CNT_EN
            chk("stall_cnt", {60'h0, stall_cnt}, m_cnt);
`endif
        end
    end

    task automatic drive(input logic rst_n, input logic fl, input logic iv,
                         input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
        reset          = rst_n;
        flush          = fl;
        fetch_if.valid = iv;
        fetch_if.pc    = pc;
        fetch_if.instr = ins;
        dec_if.ready   = ordy;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0;
        fetch_if.valid = 1'b0; fetch_if.pc = '0; fetch_if.instr = '0;
        dec_if.ready = 1'b0;

        // 1: reset then stream
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_out_valid", dec_if.valid, 0);
        chk("rst_in_ready", fetch_if.ready, 1);
        chk("rst_out_instr", dec_if.instr, NOP);
        chk("rst_out_pc", dec_if.pc, 0);
        drive(1, 0, 1, 4, 32'hA, 1);
        chk("s1_pc4", dec_if.pc, 4);
        chk("s1_valid", dec_if.valid, 1);
        drive(1, 0, 1, 8, 32'hB, 1);
        chk("s1_pc8", dec_if.pc, 8);
        drive(1, 0, 1, 12, 32'hC, 1);
        chk("s1_pc12", dec_if.pc, 12);
        chk("s1_instrC", dec_if.instr, 32'hC);
        drive(1, 0, 0, 0, 0, 1);
        chk("s1_drained", dec_if.valid, 0);
        chk("s1_retained", dec_if.pc, 12);

        // 2: back-pressure
        drive(1, 0, 1, 4, 32'h4, 0);
        drive(1, 0, 1, 8, 32'h8, 0);
        chk("bp_in_ready", fetch_if.ready, 0);
        chk("bp_hold_pc", dec_if.pc, 4);
        drive(1, 0, 0, 0, 0, 1);
        chk("bp_next_pc", dec_if.pc, 8);
        chk("bp_ready_back", fetch_if.ready, 1);
        drive(1, 0, 0, 0, 0, 1);
        chk("bp_empty", dec_if.valid, 0);

        // 3: flush while FULL with an incoming beat
        drive(1, 0, 1, 4, 32'h4, 0);
        drive(1, 0, 1, 8, 32'h8, 0);
        drive(1, 1, 1, 32'h40, 32'h40, 0);
        chk("fl_valid", dec_if.valid, 0);
        chk("fl_instr", dec_if.instr, NOP);
        chk("fl_pc", dec_if.pc, 0);
        chk("fl_ready", fetch_if.ready, 1);
        drive(1, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1);

        // 4: reset wins over flush
        drive(1, 0, 1, 4, 32'h1, 1);
        drive(1, 0, 1, 8, 32'h2, 1);
        drive(0, 1, 1, 12, 32'h3, 0);
        chk("rf_valid", dec_if.valid, 0);
        chk("rf_ready", fetch_if.ready, 1);
        chk("rf_pc", dec_if.pc, 0);
        chk("rf_instr", dec_if.instr, NOP);
        drive(1, 0, 1, 32'h100, 32'h55, 1);
        chk("rf_pc100", dec_if.pc, 32'h100);
        chk("rf_valid100", dec_if.valid, 1);

        // 5: continuous stream in ONE
        for (int p = 4; p <= 20; p += 4) begin
            drive(1, 0, 1, p, 32'h900 + p, 1);
            chk("ss_pc", dec_if.pc, p);
            chk("ss_ready", fetch_if.ready, 1);
        end
        drive(1, 0, 0, 0, 0, 1);

`ifdef PIPE_STALL_CNT_EN
        // 6: stall counter saturation, survives flush, cleared by reset
        drive(0, 0, 0, 0, 0, 0);
        chk("sc_rst", stall_cnt, 0);
        drive(1, 0, 1, 4, 32'h4, 0);
        for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0, 0);
        chk("sc_sat", stall_cnt, 15);
        drive(1, 1, 0, 0, 0, 0);
        chk("sc_flush_keep", stall_cnt, 15);
        drive(0, 0, 0, 0, 0, 0);
        chk("sc_reset_clr", stall_cnt, 0);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom, $urandom,
                  ($urandom_range(0, 2) != 0));
        end
        drive(1, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
